coproc_mem_arbiter: RTL and testbench
=====================================

// Module: coproc_mem_arbiter
// PURPOSE
// Shares the single X-interface memory request/result channel of the coprocessor between NUM_REQ
// internal engines (wbits read engine, future store/gather engines). Round-robin arbitration, one
// registered request in flight on the mem channel, in-order result routing via an outstanding-index FIFO.
// Sits between the engines' memory FSMs and xif_mem/xif_mem_result inside coproc.
// PARAMETERS
// NUM_REQ     2   number of requesting engines (>=2)
// ID_W        4   width of XIF instruction id
// OUTST_DEPTH 2   max accepted-but-unanswered mem transactions (power of 2, >=1)
// PORTS
// clk_i              in   1             clock
// rst_ni             in   1             async active-low reset
// req_valid_i        in   NUM_REQ       engine k requests a transfer
// req_ready_o        out  NUM_REQ       one-cycle pulse: engine k payload captured
// req_addr_i         in   NUM_REQ*32    byte address, slice k
// req_we_i           in   NUM_REQ       write enable, bit k
// req_be_i           in   NUM_REQ*4     byte enables, slice k
// req_wdata_i        in   NUM_REQ*32    write data, slice k
// req_id_i           in   NUM_REQ*ID_W  XIF instruction id, slice k
// rsp_valid_o        out  NUM_REQ       one-cycle pulse: result for engine k on rsp_rdata_o
// rsp_rdata_o        out  32            result data (shared by all engines)
// mem_valid_o        out  1             XIF mem_valid
// mem_ready_i        in   1             XIF mem_ready
// mem_addr_o/we_o/be_o/wdata_o/id_o out 32/1/4/32/ID_W  XIF mem_req fields, registered
// mem_result_valid_i in   1             XIF mem_result_valid
// mem_result_rdata_i in   32            XIF mem_result.rdata
// busy_o             out  1             state!=IDLE or FIFO non-empty
// spurious_o         out  1             sticky: result arrived with FIFO empty
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, rr pointer 0, FIFO empty, spurious_o cleared.
// - FSM IDLE: if any req_valid_i and count<OUTST_DEPTH: grant g = first valid index at/after rr
//   pointer (wrapping mod NUM_REQ); req_ready_o[g]=1 that cycle (combinational); capture g's payload
//   into mem_*_o and g into grant reg; rr <= (g+1) mod NUM_REQ; next state REQ. Else stay IDLE.
// - FSM REQ: mem_valid_o=1, mem_*_o stable. On mem_valid_o&&mem_ready_i: push grant index to FIFO,
//   mem_valid_o drops next cycle, state IDLE. No new grant in the handshake cycle (min 2 cycles/xfer).
// - count==OUTST_DEPTH blocks grants even if a pop happens the same cycle.
// - Results: on mem_result_valid_i with FIFO non-empty: pop head h; next cycle rsp_valid_o[h]=1
//   (single pulse) and rsp_rdata_o=registered rdata. rsp_rdata_o holds value until next result.
// - Result with FIFO empty (including same cycle as first push): dropped, spurious_o<=1, FIFO untouched.
// - Push and pop in same cycle: both performed, count unchanged.
// - req_valid_i deasserted while not granted: no effect; engines must hold payload until req_ready_o.
// - Async reset mid-operation: mem_valid_o and rsp_valid_o drop immediately; outstanding entries lost.
// - Pointers wrap mod OUTST_DEPTH; count is $clog2(OUTST_DEPTH)+1 bits.
// TESTING
// 1 Single req: req_valid_i=01, addr0=0x100, mem_ready_i=1 -> ready pulse cycle0, mem_valid_o cycles1,
//   addr 0x100; result rdata 0xDEADBEEF -> rsp_valid_o=01 next cycle, rsp_rdata_o=0xDEADBEEF.
// 2 Round-robin: both valid continuously -> grants 0,1,0,1; mem_addr_o alternates addr0/addr1.
// 3 Backpressure: mem_ready_i low 5 cycles -> mem_valid_o high 5+1 cycles, mem_addr_o constant,
//   no second req_ready_o.
// 4 FIFO full (DEPTH=2): two handshakes, no results -> third req stalls; one result -> grant resumes;
//   results 0xA,0xB routed to engines in grant order.
// 5 Spurious: mem_result_valid_i with FIFO empty -> no rsp_valid_o, spurious_o=1 until reset.
// 6 Reset in REQ: rst_ni low -> mem_valid_o=0 immediately, busy_o=0; after release first grant is idx0.

Source files
------------

// File: rtl/coproc_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : coproc_mem_arbiter_if
// Brief   : Engine request/response and XIF memory channel bundle for the
//           coprocessor memory arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface coproc_mem_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 4
);

  // Engine-side request/response
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*32-1:0]   req_addr;
  logic [NUM_REQ-1:0]      req_we;
  logic [NUM_REQ*4-1:0]    req_be;
  logic [NUM_REQ*32-1:0]   req_wdata;
  logic [NUM_REQ*ID_W-1:0] req_id;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic [31:0]             rsp_rdata;

  // XIF memory request/result channel
  logic                    mem_valid;
  logic                    mem_ready;
  logic [31:0]             mem_addr;
  logic                    mem_we;
  logic [3:0]              mem_be;
  logic [31:0]             mem_wdata;
  logic [ID_W-1:0]         mem_id;
  logic                    mem_result_valid;
  logic [31:0]             mem_result_rdata;

  // Status
  logic                    busy;
  logic                    spurious;

  // Arbiter view
  modport slave (
    input  req_valid, req_addr, req_we, req_be, req_wdata, req_id,
    input  mem_ready, mem_result_valid, mem_result_rdata,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_valid, mem_addr, mem_we, mem_be, mem_wdata, mem_id,
    output busy, spurious
  );

  // Engines plus memory view
  modport master (
    output req_valid, req_addr, req_we, req_be, req_wdata, req_id,
    output mem_ready, mem_result_valid, mem_result_rdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_valid, mem_addr, mem_we, mem_be, mem_wdata, mem_id,
    input  busy, spurious
  );

endinterface
`default_nettype wire

// File: rtl/coproc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : coproc_mem_arbiter
// Brief   : Round-robin arbiter sharing one XIF memory channel among NUM_REQ
//           engines; one registered request in flight, in-order result
//           routing through an outstanding-index FIFO.
// Revision: 1.0 - initial release
// ============================================================================
module coproc_mem_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ID_W        = 4,
  parameter int OUTST_DEPTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  coproc_mem_arbiter_if.slave  bus
);

  localparam int c_idx_w = $clog2(NUM_REQ);
  localparam int c_ptr_w = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;
  localparam int c_cnt_w = $clog2(OUTST_DEPTH) + 1;
  localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(OUTST_DEPTH);
  localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(OUTST_DEPTH - 1);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_idx_w-1:0]   r_rr;
  logic [c_idx_w-1:0]   r_grant;
  logic [c_idx_w-1:0]   w_cand;
  logic [c_idx_w-1:0]   w_grant_idx;
  logic                 w_found;
  logic                 w_grant_en;
  logic                 w_push;
  logic                 w_pop;
  logic [NUM_REQ-1:0]   w_req_ready;

  logic [c_idx_w-1:0]   r_fifo [OUTST_DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]   r_count;

  logic [31:0]          r_mem_addr;
  logic                 r_mem_we;
  logic [3:0]           r_mem_be;
  logic [31:0]          r_mem_wdata;
  logic [ID_W-1:0]      r_mem_id;
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic [31:0]          r_rsp_rdata;
  logic                 r_spurious;

  // A result is only routable when something is outstanding; the pre-push
  // count is used so a result coinciding with the first push is spurious.
  assign w_pop = bus.mem_result_valid && (r_count != '0);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Round-robin search, grant decision and handshake detection
  always_comb begin
    w_state_nxt = r_state;
    w_cand      = '0;
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_grant_en  = 1'b0;
    w_push      = 1'b0;
    w_req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = c_idx_w'((int'(r_rr) + i) % NUM_REQ);
      if (!w_found && bus.req_valid[w_cand]) begin
        w_found     = 1'b1;
        w_grant_idx = w_cand;
      end
    end
    case (r_state)
      S_IDLE: begin
        // A full FIFO blocks the grant even if a pop lands this cycle.
        if (w_found && (r_count < c_depth)) begin
          w_grant_en               = 1'b1;
          w_req_ready[w_grant_idx] = 1'b1;
          w_state_nxt              = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.mem_ready) begin
          w_push      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Capture granted payload and advance the round-robin pointer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr        <= '0;
      r_grant     <= '0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
      r_mem_id    <= '0;
    end else if (w_grant_en) begin
      r_rr        <= (w_grant_idx == c_idx_last) ? '0 : w_grant_idx + 1'b1;
      r_grant     <= w_grant_idx;
      r_mem_addr  <= bus.req_addr[w_grant_idx*32 +: 32];
      r_mem_we    <= bus.req_we[w_grant_idx];
      r_mem_be    <= bus.req_be[w_grant_idx*4 +: 4];
      r_mem_wdata <= bus.req_wdata[w_grant_idx*32 +: 32];
      r_mem_id    <= bus.req_id[w_grant_idx*ID_W +: ID_W];
    end
  end

  // Outstanding-index FIFO: push on mem handshake, pop on routed result
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < OUTST_DEPTH; i++) r_fifo[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= r_grant;
        r_wr_ptr         <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // Result routing pulse, held result data and sticky spurious flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_spurious  <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      if (w_pop) begin
        r_rsp_valid[r_fifo[r_rd_ptr]] <= 1'b1;
        r_rsp_rdata                   <= bus.mem_result_rdata;
      end
      if (bus.mem_result_valid && (r_count == '0)) r_spurious <= 1'b1;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.mem_valid = (r_state == S_REQ);
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_be    = r_mem_be;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_id    = r_mem_id;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.busy      = (r_state != S_IDLE) || (r_count != '0);
  assign bus.spurious  = r_spurious;

endmodule
`default_nettype wire

// File: tb/tb_coproc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_coproc_mem_arbiter
// Brief   : Directed self-checking bench for coproc_mem_arbiter
//           (NUM_REQ=2, ID_W=4, OUTST_DEPTH=2).
// Revision: 1.0 - initial release
// ============================================================================
module tb_coproc_mem_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  coproc_mem_arbiter_if #(.NUM_REQ(2), .ID_W(4)) bus ();

  coproc_mem_arbiter #(
    .NUM_REQ    (2),
    .ID_W       (4),
    .OUTST_DEPTH(2)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_g [4] = '{1, 0, 1, 0};

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid        = '0;
    bus.req_addr         = {32'h0000_0200, 32'h0000_0100};
    bus.req_we           = 2'b10;
    bus.req_be           = 8'hFF;
    bus.req_wdata        = {32'h2222_2222, 32'h1111_1111};
    bus.req_id           = {4'd5, 4'd3};
    bus.mem_ready        = 1'b0;
    bus.mem_result_valid = 1'b0;
    bus.mem_result_rdata = '0;

    // Reset state
    #2;
    chk("rst_ready",    32'(bus.req_ready), 32'h0);
    chk("rst_mem_valid",32'(bus.mem_valid), 32'h0);
    chk("rst_rsp_valid",32'(bus.rsp_valid), 32'h0);
    chk("rst_busy",     32'(bus.busy),      32'h0);
    chk("rst_spurious", 32'(bus.spurious),  32'h0);
    chk("rst_mem_addr", bus.mem_addr,       32'h0);
    tick(); tick();
    rst_n = 1'b1;

    // 1: single request from engine 0
    tick();
    bus.req_valid = 2'b01;
    bus.mem_ready = 1'b1;
    #1;
    chk("t1_ready",     32'(bus.req_ready), 32'h1);
    chk("t1_mv_grant",  32'(bus.mem_valid), 32'h0);
    tick();
    bus.req_valid = 2'b00;
    #1;
    chk("t1_mem_valid", 32'(bus.mem_valid), 32'h1);
    chk("t1_mem_addr",  bus.mem_addr,       32'h100);
    chk("t1_mem_id",    32'(bus.mem_id),    32'h3);
    chk("t1_mem_we",    32'(bus.mem_we),    32'h0);
    chk("t1_mem_wdata", bus.mem_wdata,      32'h1111_1111);
    chk("t1_no_ready",  32'(bus.req_ready), 32'h0);
    chk("t1_busy",      32'(bus.busy),      32'h1);
    tick();
    #1;
    chk("t1_mv_drop",   32'(bus.mem_valid), 32'h0);
    chk("t1_busy_out",  32'(bus.busy),      32'h1);
    bus.mem_result_valid = 1'b1;
    bus.mem_result_rdata = 32'hDEAD_BEEF;
    tick();
    bus.mem_result_valid = 1'b0;
    #1;
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t1_rsp_rdata", bus.rsp_rdata,      32'hDEAD_BEEF);
    chk("t1_busy_done", 32'(bus.busy),      32'h0);
    tick();
    #1;
    chk("t1_rsp_pulse", 32'(bus.rsp_valid), 32'h0);
    chk("t1_rdata_hold",bus.rsp_rdata,      32'hDEAD_BEEF);

    // 2: both engines valid continuously; rr pointer is 1 after test 1
    for (int t = 0; t < 4; t++) begin
      tick();
      bus.req_valid        = 2'b11;
      bus.mem_result_valid = (t > 0);
      bus.mem_result_rdata = 32'h1000 + 32'(t) - 32'h1;
      #1;
      chk("t2_ready", 32'(bus.req_ready), 32'h1 << exp_g[t]);
      tick();
      bus.mem_result_valid = 1'b0;
      #1;
      chk("t2_mem_valid", 32'(bus.mem_valid), 32'h1);
      chk("t2_mem_addr",  bus.mem_addr, (exp_g[t] == 1) ? 32'h200 : 32'h100);
      chk("t2_no_ready",  32'(bus.req_ready), 32'h0);
      if (t > 0) begin
        chk("t2_rsp_valid", 32'(bus.rsp_valid), 32'h1 << exp_g[t-1]);
        chk("t2_rsp_rdata", bus.rsp_rdata, 32'h1000 + 32'(t) - 32'h1);
      end
    end
    tick();
    bus.req_valid        = 2'b00;
    bus.mem_result_valid = 1'b1;
    bus.mem_result_rdata = 32'h1003;
    #1;
    chk("t2_mv_drop", 32'(bus.mem_valid), 32'h0);
    tick();
    bus.mem_result_valid = 1'b0;
    #1;
    chk("t2_last_rsp",   32'(bus.rsp_valid), 32'h1);
    chk("t2_last_rdata", bus.rsp_rdata,      32'h1003);
    chk("t2_idle",       32'(bus.busy),      32'h0);

    // 3: backpressure, mem_ready low for 5 cycles
    tick();
    bus.req_addr[31:0] = 32'h300;
    bus.req_valid      = 2'b01;
    bus.mem_ready      = 1'b0;
    #1;
    chk("t3_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 2'b11;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_mem_valid", 32'(bus.mem_valid), 32'h1);
      chk("t3_mem_addr",  bus.mem_addr,       32'h300);
      chk("t3_no_ready",  32'(bus.req_ready), 32'h0);
      tick();
      #1;
    end
    bus.mem_ready = 1'b1;
    bus.req_valid = 2'b00;
    #1;
    chk("t3_mv_last",   32'(bus.mem_valid), 32'h1);
    chk("t3_addr_last", bus.mem_addr,       32'h300);
    tick();
    #1;
    chk("t3_mv_drop", 32'(bus.mem_valid), 32'h0);
    bus.mem_result_valid = 1'b1;
    bus.mem_result_rdata = 32'h55;
    tick();
    bus.mem_result_valid = 1'b0;
    #1;
    chk("t3_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t3_rsp_rdata", bus.rsp_rdata,      32'h55);

    // 4: FIFO full; rr pointer is 1
    tick();
    bus.req_addr[31:0] = 32'h100;
    bus.req_valid      = 2'b11;
    #1;
    chk("t4_ready_a", 32'(bus.req_ready), 32'h2);
    tick();
    #1;
    chk("t4_addr_a", bus.mem_addr, 32'h200);
    tick();
    #1;
    chk("t4_ready_b", 32'(bus.req_ready), 32'h1);
    tick();
    #1;
    chk("t4_addr_b", bus.mem_addr, 32'h100);
    tick();
    #1;
    chk("t4_full_stall", 32'(bus.req_ready), 32'h0);
    chk("t4_full_busy",  32'(bus.busy),      32'h1);
    chk("t4_full_mv",    32'(bus.mem_valid), 32'h0);
    tick();
    bus.mem_result_valid = 1'b1;
    bus.mem_result_rdata = 32'hA;
    #1;
    chk("t4_full_pop_stall", 32'(bus.req_ready), 32'h0);
    tick();
    bus.mem_result_valid = 1'b0;
    #1;
    chk("t4_rsp_a",    32'(bus.rsp_valid), 32'h2);
    chk("t4_rdata_a",  bus.rsp_rdata,      32'hA);
    chk("t4_resume",   32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid        = 2'b00;
    bus.mem_result_valid = 1'b1;
    bus.mem_result_rdata = 32'hB;
    #1;
    chk("t4_pushpop_mv",   32'(bus.mem_valid), 32'h1);
    chk("t4_pushpop_addr", bus.mem_addr,       32'h200);
    tick();
    bus.mem_result_rdata = 32'hC;
    #1;
    chk("t4_rsp_b",   32'(bus.rsp_valid), 32'h1);
    chk("t4_rdata_b", bus.rsp_rdata,      32'hB);
    chk("t4_busy_b",  32'(bus.busy),      32'h1);
    tick();
    bus.mem_result_valid = 1'b0;
    #1;
    chk("t4_rsp_c",   32'(bus.rsp_valid), 32'h2);
    chk("t4_rdata_c", bus.rsp_rdata,      32'hC);
    chk("t4_busy_c",  32'(bus.busy),      32'h0);

    // 5: result with empty FIFO
    tick();
    bus.mem_result_valid = 1'b1;
    bus.mem_result_rdata = 32'h77;
    #1;
    chk("t5_spur_before", 32'(bus.spurious), 32'h0);
    tick();
    bus.mem_result_valid = 1'b0;
    #1;
    chk("t5_no_rsp",   32'(bus.rsp_valid), 32'h0);
    chk("t5_spurious", 32'(bus.spurious),  32'h1);
    chk("t5_rdata",    bus.rsp_rdata,      32'hC);
    tick();
    tick();
    #1;
    chk("t5_sticky", 32'(bus.spurious), 32'h1);

    // 6: async reset while in REQ; rr pointer is 0, becomes 1 on this grant
    tick();
    bus.req_valid = 2'b01;
    bus.mem_ready = 1'b0;
    #1;
    chk("t6_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 2'b00;
    #1;
    chk("t6_mv", 32'(bus.mem_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_mv",    32'(bus.mem_valid), 32'h0);
    chk("t6_rst_busy",  32'(bus.busy),      32'h0);
    chk("t6_rst_spur",  32'(bus.spurious),  32'h0);
    chk("t6_rst_rdata", bus.rsp_rdata,      32'h0);
    tick();
    rst_n         = 1'b1;
    bus.req_valid = 2'b11;
    #1;
    chk("t6_first_grant", 32'(bus.req_ready), 32'h1);
    bus.req_valid = 2'b00;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
